// File: rtl/mult_arb.sv
// Two-requester multiply/accumulate unit sharing one 16x16 multiplier.
// Round-robin grant, fixed 2-cycle latency from grant to rvalid, one 32-bit accumulator per requester.

module mp16 #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic [DATA_W-1:0]        a,
    input  logic [COEF_W-1:0]        b,
    input  logic                     sign,
    output logic [DATA_W+COEF_W-1:0] p
);
    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] p_s;

    // Extending both operands to full width makes the low PW product bits exact for either signedness.
    assign a_ext = {{COEF_W{sign & a[DATA_W-1]}}, a};
    assign b_ext = {{DATA_W{sign & b[COEF_W-1]}}, b};
    assign p_s   = a_ext * b_ext;
    assign p     = p_s;
endmodule

module mult_arb #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [DATA_W-1:0]        a0,
    input  logic [DATA_W-1:0]        a1,
    input  logic [COEF_W-1:0]        b0,
    input  logic [COEF_W-1:0]        b1,
    input  logic                     sign0,
    input  logic                     sign1,
    input  logic                     acc0,
    input  logic                     acc1,
    input  logic                     acc_clr0,
    input  logic                     acc_clr1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic [DATA_W+COEF_W-1:0] res,
    output logic                     rvalid0,
    output logic                     rvalid1
);
    localparam int RW = DATA_W + COEF_W;

    logic              prio;
    logic              vld_p0;
    logic [DATA_W-1:0] a_p0;
    logic [COEF_W-1:0] b_p0;
    logic              sign_p0;
    logic              acc_p0;

    logic              vld_p1;
    logic              tag_p1;
    logic [DATA_W-1:0] a_p1;
    logic [COEF_W-1:0] b_p1;
    logic              sign_p1;
    logic              acc_p1;
    logic [RW-1:0]     prod_p1;
    logic [RW-1:0]     base_p1;
    logic [RW-1:0]     sum_p1;

    logic [RW-1:0]     accum0;
    logic [RW-1:0]     accum1;

    function automatic logic [RW-1:0] acc_wrap(input logic add, input logic [RW-1:0] base,
                                               input logic [RW-1:0] prod);
        return add ? base + prod : prod;
    endfunction

    // Stage 0: round-robin grant; prio names the requester favoured on a collision
    assign gnt0    = !reset && req0 && (!req1 || !prio);
    assign gnt1    = !reset && req1 && (!req0 ||  prio);
    assign vld_p0  = gnt0 || gnt1;
    assign a_p0    = gnt1 ? a1    : a0;
    assign b_p0    = gnt1 ? b1    : b0;
    assign sign_p0 = gnt1 ? sign1 : sign0;
    assign acc_p0  = gnt1 ? acc1  : acc0;

    always_ff @(posedge sys_clk) begin
        if (vld_p0) begin
            a_p1    <= a_p0;
            b_p1    <= b_p0;
            sign_p1 <= sign_p0;
            acc_p1  <= acc_p0;
        end
    end

    // Stage 1 -> 2: multiply and accumulate in one cycle so same-requester chains never stall
    mp16 #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W)
    ) u_mp16 (
        .a   (a_p1),
        .b   (b_p1),
        .sign(sign_p1),
        .p   (prod_p1)
    );

    assign base_p1 = tag_p1 ? accum1 : accum0;
    assign sum_p1  = acc_wrap(acc_p1, base_p1, prod_p1);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            prio    <= 1'b0;
            vld_p1  <= 1'b0;
            tag_p1  <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            res     <= '0;
            accum0  <= '0;
            accum1  <= '0;
        end else begin
            if (vld_p0) begin
                prio   <= gnt0;
                tag_p1 <= gnt1;
            end
            vld_p1  <= vld_p0;
            rvalid0 <= vld_p1 && !tag_p1;
            rvalid1 <= vld_p1 &&  tag_p1;
            if (vld_p1) res <= sum_p1;
            // A completing result takes priority over a same-cycle clear
            if (vld_p1 && !tag_p1) accum0 <= sum_p1;
            else if (acc_clr0)     accum0 <= '0;
            if (vld_p1 && tag_p1)  accum1 <= sum_p1;
            else if (acc_clr1)     accum1 <= '0;
        end
    end
endmodule

// File: tb/tb_mult_arb.sv
// Directed bench for mult_arb: arbitration, signed/unsigned products, accumulate chains, clears and reset.

module tb_mult_arb;
    logic        sys_clk = 1'b0;
    logic        reset   = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic        sign0 = 1'b0, sign1 = 1'b0;
    logic        acc0 = 1'b0, acc1 = 1'b0;
    logic        acc_clr0 = 1'b0, acc_clr1 = 1'b0;
    logic        gnt0, gnt1;
    logic [31:0] res;
    logic        rvalid0, rvalid1;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    mult_arb dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .a1      (a1),
        .b0      (b0),
        .b1      (b1),
        .sign0   (sign0),
        .sign1   (sign1),
        .acc0    (acc0),
        .acc1    (acc1),
        .acc_clr0(acc_clr0),
        .acc_clr1(acc_clr1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .res     (res),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ac);
        req0 = r; a0 = a; b0 = b; sign0 = s; acc0 = ac;
    endtask

    task automatic set1(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ac);
        req1 = r; a1 = a; b1 = b; sign1 = s; acc1 = ac;
    endtask

    initial begin
        // reset state, with both requests already pending
        #1;
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_res", res, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        cyc();
        cyc();

        // Scenario 3: both held from release, alternating grants and results
        set0(1, 16'd1, 16'd1, 0, 0);
        set1(1, 16'd2, 16'd1, 0, 0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_gnt0", gnt0, (i % 2 == 0));
            chk("rr_gnt1", gnt1, (i % 2 == 1));
            chk("rr_rvalid0", rvalid0, (i >= 2) && (i % 2 == 0));
            chk("rr_rvalid1", rvalid1, (i >= 2) && (i % 2 == 1));
            if (i >= 2) chk("rr_res", res, (i % 2 == 0) ? 32'd1 : 32'd2);
            cyc();
            #1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("rr_tail_rvalid0", rvalid0, 1);
        chk("rr_tail_res0", res, 1);
        cyc();
        chk("rr_tail_rvalid1", rvalid1, 1);
        chk("rr_tail_res1", res, 2);
        cyc();
        chk("rr_drain_rvalid0", rvalid0, 0);
        chk("rr_drain_rvalid1", rvalid1, 0);

        // Scenario 1: lone requester 0, 3*5
        cyc(); set0(1, 16'd3, 16'd5, 0, 0); #1;
        chk("s1_gnt0", gnt0, 1);
        chk("s1_gnt1", gnt1, 0);
        cyc(); req0 = 1'b0; #1;
        chk("s1_rvalid0_t1", rvalid0, 0);
        cyc(); #1;
        chk("s1_rvalid0_t2", rvalid0, 1);
        chk("s1_rvalid1_t2", rvalid1, 0);
        chk("s1_res", res, 32'h0000000F);
        cyc(); #1;
        chk("s1_rvalid0_t3", rvalid0, 0);
        chk("s1_res_hold", res, 32'h0000000F);

        // Scenario 2: 0xFFFF * 2 signed then unsigned, back to back
        cyc(); set1(1, 16'hFFFF, 16'h0002, 1, 0); #1;
        chk("s2_gnt1_a", gnt1, 1);
        chk("s2_gnt0_a", gnt0, 0);
        cyc(); sign1 = 1'b0; #1;
        chk("s2_gnt1_b", gnt1, 1);
        cyc(); req1 = 1'b0; #1;
        chk("s2_rvalid1_signed", rvalid1, 1);
        chk("s2_rvalid0_signed", rvalid0, 0);
        chk("s2_res_signed", res, 32'hFFFFFFFE);
        cyc(); #1;
        chk("s2_rvalid1_unsigned", rvalid1, 1);
        chk("s2_res_unsigned", res, 32'h0001FFFE);
        cyc(); #1;
        chk("s2_rvalid1_idle", rvalid1, 0);

        // Scenario 4: load 2*3 then accumulate 4*5
        cyc(); set1(1, 16'd2, 16'd3, 0, 0); #1;
        cyc(); set1(1, 16'd4, 16'd5, 0, 1); #1;
        cyc(); req1 = 1'b0; #1;
        chk("s4_rvalid1_a", rvalid1, 1);
        chk("s4_res_load", res, 32'd6);
        cyc(); #1;
        chk("s4_rvalid1_b", rvalid1, 1);
        chk("s4_res_acc", res, 32'd26);

        // Scenario 5: wrap to zero, then clear before accumulate
        cyc(); set1(1, 16'hFFFF, 16'd1, 1, 0); #1;
        cyc(); set1(1, 16'd1, 16'd1, 0, 1); #1;
        cyc(); req1 = 1'b0; #1;
        chk("s5_res_ones", res, 32'hFFFFFFFF);
        cyc(); #1;
        chk("s5_rvalid1_wrap", rvalid1, 1);
        chk("s5_res_wrap", res, 32'h00000000);
        cyc(); set1(1, 16'd7, 16'd1, 0, 0); #1;
        cyc(); req1 = 1'b0; #1;
        cyc(); #1;
        chk("s5_res_seven", res, 32'd7);
        cyc(); acc_clr1 = 1'b1; #1;
        cyc(); acc_clr1 = 1'b0; set1(1, 16'd4, 16'd4, 0, 1); #1;
        cyc(); req1 = 1'b0; #1;
        cyc(); #1;
        chk("s5_rvalid1_clr", rvalid1, 1);
        chk("s5_res_after_clr", res, 32'h00000010);

        // result write beats a same-cycle clear
        cyc(); set1(1, 16'd3, 16'd3, 0, 0); #1;
        cyc(); req1 = 1'b0; acc_clr1 = 1'b1; #1;
        cyc(); acc_clr1 = 1'b0; set1(1, 16'd1, 16'd1, 0, 1); #1;
        chk("clr_race_res", res, 32'd9);
        cyc(); req1 = 1'b0; #1;
        cyc(); #1;
        chk("clr_race_acc", res, 32'd10);

        // accumulator 0 untouched by requester 1 traffic
        cyc(); set0(1, 16'd1, 16'd2, 0, 1); #1;
        chk("acc0_gnt0", gnt0, 1);
        cyc(); req0 = 1'b0; #1;
        cyc(); #1;
        chk("acc0_rvalid0", rvalid0, 1);
        chk("acc0_res", res, 32'd17);

        // Scenario 6: reset one cycle after a grant discards the operation
        cyc(); set0(1, 16'd5, 16'd5, 0, 0); #1;
        chk("s6_gnt0", gnt0, 1);
        cyc();
        set0(1, 16'd5, 16'd5, 0, 1);
        set1(1, 16'd6, 16'd1, 0, 1);
        reset = 1'b1;
        #1;
        chk("s6_rst_gnt0", gnt0, 0);
        chk("s6_rst_gnt1", gnt1, 0);
        chk("s6_rst_res", res, 0);
        chk("s6_rst_rvalid0", rvalid0, 0);
        cyc();
        chk("s6_lost_rvalid0", rvalid0, 0);
        chk("s6_lost_res", res, 0);
        reset = 1'b0;
        #1;
        chk("s6_rel_gnt0", gnt0, 1);
        chk("s6_rel_gnt1", gnt1, 0);
        cyc(); #1;
        chk("s6_next_gnt1", gnt1, 1);
        chk("s6_next_rvalid0", rvalid0, 0);
        chk("s6_next_rvalid1", rvalid1, 0);
        chk("s6_next_res", res, 0);
        cyc(); req0 = 1'b0; req1 = 1'b0; #1;
        chk("s6_rvalid0", rvalid0, 1);
        chk("s6_res0", res, 32'd25);
        cyc(); #1;
        chk("s6_rvalid1", rvalid1, 1);
        chk("s6_res1", res, 32'd6);
        cyc(); #1;
        chk("s6_idle_rvalid0", rvalid0, 0);
        chk("s6_idle_rvalid1", rvalid1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
